// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined KSIZE x KSIZE convolution multiply-accumulate.
// Each beat multiplies a pixel window by a kernel window (S1), reduces the
// products (S2) and folds the sum into a per-pixel accumulator (S3) that
// spans NUM_CHANNELS beats plus a bias. The completed accumulator is rounded
// half-up, shifted right by FRAC_BITS and saturated to OUT_WIDTH.
// A single global enable stalls every stage while a result waits downstream.
module conv_mac_pipe #(
  parameter int PIXEL_WIDTH  = 16,
  parameter int KERNEL_WIDTH = 16,
  parameter int RESULT_WIDTH = 48,
  parameter int KSIZE        = 3,
  parameter int NUM_CHANNELS = 4,
  parameter int FRAC_BITS    = 8,
  parameter int OUT_WIDTH    = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [KSIZE*KSIZE*PIXEL_WIDTH-1:0]      in_pixels,
  input  logic [KSIZE*KSIZE*KERNEL_WIDTH-1:0]     in_kernel,
  input  logic [RESULT_WIDTH-1:0]                 in_bias,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [OUT_WIDTH-1:0]                    out_data,
  output logic [RESULT_WIDTH-1:0]                 out_acc,
  output logic                                    out_sat
);

  localparam int TAPS  = KSIZE * KSIZE;
  localparam int MW    = PIXEL_WIDTH + KERNEL_WIDTH;
  localparam int CNT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CHANNELS - 1);
  localparam logic [CNT_W-1:0] CH_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CH_ONE  = CNT_W'(1);

  // Round-half-up bias: 2^(FRAC_BITS-1), or zero when there is no shift.
  localparam logic signed [RESULT_WIDTH:0] HALF =
    $signed(((RESULT_WIDTH+1)'(1) << FRAC_BITS) >> 1);
  // Saturation limits held one bit wider than the accumulator so the
  // rounding addition can never wrap before the compare.
  localparam logic signed [RESULT_WIDTH:0] SAT_MAX =
    $signed({{(RESULT_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [RESULT_WIDTH:0] SAT_MIN =
    $signed({{(RESULT_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}});
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic                                  en_s;
  logic [TAPS-1:0][RESULT_WIDTH-1:0]     prod_s;
  logic signed [MW-1:0]                  pix_ext_s;
  logic signed [MW-1:0]                  ker_ext_s;
  logic signed [MW-1:0]                  mult_s;
  logic [RESULT_WIDTH-1:0]               sum_s;
  logic [RESULT_WIDTH-1:0]               acc_next_s;
  logic                                  wrap_s;
  logic signed [RESULT_WIDTH:0]          rnd_s;
  logic signed [RESULT_WIDTH:0]          shift_s;
  logic [OUT_WIDTH-1:0]                  sat_data_s;
  logic                                  sat_flag_s;

  logic                                  s1_valid_r;
  logic [TAPS-1:0][RESULT_WIDTH-1:0]     s1_prod_r;
  logic [RESULT_WIDTH-1:0]               s1_bias_r;
  logic                                  s2_valid_r;
  logic [RESULT_WIDTH-1:0]               s2_sum_r;
  logic [RESULT_WIDTH-1:0]               s2_bias_r;
  logic [RESULT_WIDTH-1:0]               acc_r;
  logic [CNT_W-1:0]                      ch_cnt_r;
  logic                                  out_valid_r;
  logic [OUT_WIDTH-1:0]                  out_data_r;
  logic [RESULT_WIDTH-1:0]               out_acc_r;
  logic                                  out_sat_r;

  // The whole pipeline moves only when no result is blocked at the output.
  assign en_s      = !out_valid_r || out_ready;
  assign in_ready  = en_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_acc   = out_acc_r;
  assign out_sat   = out_sat_r;

  // Per-tap signed products, sign-extended to the accumulator width.
  always_comb begin
    prod_s    = {(TAPS*RESULT_WIDTH){1'b0}};
    pix_ext_s = {MW{1'b0}};
    ker_ext_s = {MW{1'b0}};
    mult_s    = {MW{1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      pix_ext_s = MW'($signed(in_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH]));
      ker_ext_s = MW'($signed(in_kernel[i*KERNEL_WIDTH +: KERNEL_WIDTH]));
      mult_s    = pix_ext_s * ker_ext_s;
      prod_s[i] = RESULT_WIDTH'(mult_s);
    end
  end

  // Reduction of the registered products; synthesis balances it into a tree.
  always_comb begin
    sum_s = {RESULT_WIDTH{1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      sum_s = sum_s + s1_prod_r[i];
    end
  end

  // Next accumulator value, completion detect, then round/shift/saturate.
  always_comb begin
    if (ch_cnt_r == CH_ZERO) begin
      acc_next_s = s2_bias_r + s2_sum_r;
    end else begin
      acc_next_s = acc_r + s2_sum_r;
    end
    wrap_s  = s2_valid_r && (ch_cnt_r == LAST_CH);
    rnd_s   = $signed({acc_next_s[RESULT_WIDTH-1], acc_next_s}) + HALF;
    shift_s = rnd_s >>> FRAC_BITS;
    if (shift_s > SAT_MAX) begin
      sat_data_s = OUT_MAX;
      sat_flag_s = 1'b1;
    end else if (shift_s < SAT_MIN) begin
      sat_data_s = OUT_MIN;
      sat_flag_s = 1'b1;
    end else begin
      sat_data_s = shift_s[OUT_WIDTH-1:0];
      sat_flag_s = 1'b0;
    end
  end

  // S1: capture products and the beat's bias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_prod_r  <= {(TAPS*RESULT_WIDTH){1'b0}};
      s1_bias_r  <= {RESULT_WIDTH{1'b0}};
    end else if (en_s) begin
      s1_valid_r <= in_valid;
      s1_prod_r  <= prod_s;
      s1_bias_r  <= in_bias;
    end
  end

  // S2: capture the reduced sum; the bias keeps travelling with its beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_sum_r   <= {RESULT_WIDTH{1'b0}};
      s2_bias_r  <= {RESULT_WIDTH{1'b0}};
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      s2_sum_r   <= sum_s;
      s2_bias_r  <= s1_bias_r;
    end
  end

  // S3: accumulate valid beats and count channels; bubbles leave both alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= {RESULT_WIDTH{1'b0}};
      ch_cnt_r <= CH_ZERO;
    end else if (en_s && s2_valid_r) begin
      acc_r <= acc_next_s;
      if (ch_cnt_r == LAST_CH) begin
        ch_cnt_r <= CH_ZERO;
      end else begin
        ch_cnt_r <= ch_cnt_r + CH_ONE;
      end
    end
  end

  // Output register: load on a completed pixel, otherwise drop once taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_WIDTH{1'b0}};
      out_acc_r   <= {RESULT_WIDTH{1'b0}};
      out_sat_r   <= 1'b0;
    end else if (en_s) begin
      if (wrap_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sat_data_s;
        out_acc_r   <= acc_next_s;
        out_sat_r   <= sat_flag_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule
